// File: rtl/wb_traffic_pkg.sv
// Shared types and constants for the Wishbone traffic master.
// Optional per-beat ack timeout is enabled with the WBM_TIMEOUT_EN macro.
package wb_traffic_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

endpackage

// File: rtl/wb_pattern_gen.sv
// Deterministic traffic pattern: expected word for beat k of a burst is seed + k (mod 2**32).
// One instance feeds both the write data path and the read-back comparison.
module wb_pattern_gen #(
  parameter int unsigned LEN_W = 8
) (
  input  logic [31:0]      seed_i,
  input  logic [LEN_W-1:0] beat_i,
  output logic [31:0]      word_o
);

  assign word_o = seed_i + 32'(beat_i);

endmodule

// File: rtl/wb_traffic_master.sv
// Wishbone classic initiator issuing single-beat bursts with a seeded pattern and read checking.
// Define WBM_TIMEOUT_EN to abort a burst when a beat waits TIMEOUT_CYC cycles for ack.
module wb_traffic_master
  import wb_traffic_pkg::*;
#(
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_seed,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] err_cnt_o,
  output logic [31:0]      first_err_adr_o,
  output logic             timeout_o
);

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      seed_q, seed_d;
  logic [31:0]      adr_q, adr_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]      first_err_q, first_err_d;
  logic             cyc_q, cyc_d;
  logic             wbm_we_q, wbm_we_d;
  logic [3:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [31:0]      expected;

  wb_pattern_gen #(
    .LEN_W (LEN_W)
  ) u_pattern (
    .seed_i (seed_q),
    .beat_i (beat_q),
    .word_o (expected)
  );

`ifdef WBM_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            timeout_q, timeout_d;
  logic            tmo_hit;

  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
  // Counter is zero on every entry to REQ because it only runs while in REQ.
  assign tmo_d   = (state_q == StReq) ? tmo_q + TmoW'(1) : '0;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    len_d       = len_q;
    seed_d      = seed_q;
    adr_d       = adr_q;
    beat_d      = beat_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
`ifdef WBM_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          we_d        = cmd_we;
          len_d       = cmd_len;
          seed_d      = cmd_seed;
          adr_d       = cmd_addr;
          beat_d      = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
`ifdef WBM_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
          state_d     = (cmd_len == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        if (wbm_ack_i) begin
          if (!we_q && (wbm_dat_i != expected)) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + LEN_W'(1);
            if (err_cnt_q == '0) first_err_d = adr_q;
          end
          state_d = (beat_q == len_q - LEN_W'(1)) ? StDone : StGap;
        end
`ifdef WBM_TIMEOUT_EN
        else if (tmo_hit) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
`endif
      end
      StGap: begin
        beat_d  = beat_q + LEN_W'(1);
        adr_d   = adr_q + ADDR_STEP;
        state_d = StReq;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    cyc_d    = (state_d == StReq);
    wbm_we_d = (state_d == StReq) && we_d;
    sel_d    = (state_d == StReq) ? WB_SEL_ALL : 4'h0;
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
    ready_d  = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      len_q       <= '0;
      seed_q      <= '0;
      adr_q       <= '0;
      beat_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      cyc_q       <= 1'b0;
      wbm_we_q    <= 1'b0;
      sel_q       <= 4'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
`ifdef WBM_TIMEOUT_EN
      tmo_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      len_q       <= len_d;
      seed_q      <= seed_d;
      adr_q       <= adr_d;
      beat_q      <= beat_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      cyc_q       <= cyc_d;
      wbm_we_q    <= wbm_we_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
`ifdef WBM_TIMEOUT_EN
      tmo_q       <= tmo_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign cmd_ready       = ready_q;
  assign wbm_cyc_o       = cyc_q;
  assign wbm_stb_o       = cyc_q;
  assign wbm_we_o        = wbm_we_q;
  assign wbm_sel_o       = sel_q;
  assign wbm_adr_o       = adr_q;
  assign wbm_dat_o       = we_q ? expected : 32'h0;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_adr_o = first_err_q;
`ifdef WBM_TIMEOUT_EN
  assign timeout_o       = timeout_q;
`else
  assign timeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_wb_traffic_master.sv
// Scoreboard bench for wb_traffic_master against a behavioural zero-wait Wishbone memory slave.
// Define WBM_TIMEOUT_EN to also exercise the ack timeout path.
module tb_wb_traffic_master;

  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready, cmd_we;
  logic [31:0]      cmd_addr, cmd_seed;
  logic [LEN_W-1:0] cmd_len;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic             busy_o, done_o, timeout_o;
  logic [LEN_W-1:0] err_cnt_o;
  logic [31:0]      first_err_adr_o;

  always #5 clk = ~clk;

  wb_traffic_master #(
    .LEN_W       (LEN_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_we          (cmd_we),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .cmd_seed        (cmd_seed),
    .wbm_cyc_o       (wbm_cyc_o),
    .wbm_stb_o       (wbm_stb_o),
    .wbm_we_o        (wbm_we_o),
    .wbm_sel_o       (wbm_sel_o),
    .wbm_adr_o       (wbm_adr_o),
    .wbm_dat_o       (wbm_dat_o),
    .wbm_dat_i       (wbm_dat_i),
    .wbm_ack_i       (wbm_ack_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_cnt_o       (err_cnt_o),
    .first_err_adr_o (first_err_adr_o),
    .timeout_o       (timeout_o)
  );

  // Behavioural slave: 256-word memory, zero-wait ack unless ack_en is cleared.
  logic [31:0] mem [0:255];
  logic        ack_en = 1'b1;
  assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & ack_en;
  assign wbm_dat_i = mem[wbm_adr_o[9:2]];
  always @(posedge clk)
    if (wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_ack_i) mem[wbm_adr_o[9:2]] <= wbm_dat_o;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic [LEN_W-1:0] err;
    logic [31:0]      first;
    logic             tmo;
  } res_t;

  beat_t beat_q[$];
  res_t  res_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int cyc_cycles = 0;
  int ack_count = 0;
  bit ignore_beats = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected beats on each ack and expected results on each done pulse.
  initial begin
    logic  prev_ack;
    beat_t b;
    res_t  r;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_ack) check("gap_cyc_low", {31'b0, wbm_cyc_o}, 32'd0);
      prev_ack = wbm_cyc_o & wbm_stb_o & wbm_ack_i;
      if (wbm_cyc_o) cyc_cycles++;
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
        ack_count++;
        if (!ignore_beats) begin
          if (beat_q.size() == 0) begin
            check("unexpected_beat_adr", wbm_adr_o, 32'hFFFF_FFFF);
          end else begin
            b = beat_q.pop_front();
            check("beat_we", {31'b0, wbm_we_o}, {31'b0, b.we});
            check("beat_adr", wbm_adr_o, b.adr);
            check("beat_dat", wbm_dat_o, b.dat);
            check("beat_sel", {28'b0, wbm_sel_o}, 32'hF);
          end
        end
      end
      if (done_o) begin
        done_seen++;
        if (res_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = res_q.pop_front();
          check("res_err_cnt", {24'b0, err_cnt_o}, {24'b0, r.err});
          check("res_first_err", first_err_adr_o, r.first);
          check("res_timeout", {31'b0, timeout_o}, {31'b0, r.tmo});
        end
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [LEN_W-1:0] len,
                          input logic [31:0] seed, input bit push_beats, input bit push_res,
                          input logic [LEN_W-1:0] exp_err, input logic [31:0] exp_first,
                          input logic exp_tmo);
    res_t r;
    int   guard;
    if (push_beats)
      for (int k = 0; k < int'(len); k++)
        beat_q.push_back('{we: we, adr: addr + 32'(4 * k), dat: we ? seed + 32'(k) : 32'h0});
    if (push_res) begin
      r = '{err: exp_err, first: exp_first, tmo: exp_tmo};
      res_q.push_back(r);
    end
    @(negedge clk);
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("cmd_ready_wait", 32'd0, 32'd1);
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_seed  = seed;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget);
    int n;
    n = 0;
    while (done_seen == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_within_budget", done_seen, start + 1);
  endtask

  initial begin
    int d0, c0, a0, guard;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h0;
    cmd_len   = '0;
    cmd_seed  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_err_cnt", {24'b0, err_cnt_o}, 32'd0);
    check("rst_first_err", first_err_adr_o, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_timeout", {31'b0, timeout_o}, 32'd0);
    rst_n = 1'b1;

    // Write burst, matching read-back, then read with shifted seed (every beat wrong).
    d0 = done_seen;
    send_cmd(1'b1, 32'h0000_0100, 8'd4, 32'hA5A5_0000, 1, 1, 8'd0, 32'h0, 1'b0);
    wait_done(d0, 40);
    check("mem_0x10C", mem[8'h43], 32'hA5A5_0003);
    d0 = done_seen;
    send_cmd(1'b0, 32'h0000_0100, 8'd4, 32'hA5A5_0000, 1, 1, 8'd0, 32'h0, 1'b0);
    wait_done(d0, 40);
    d0 = done_seen;
    send_cmd(1'b0, 32'h0000_0100, 8'd4, 32'hA5A5_0001, 1, 1, 8'd4, 32'h0000_0100, 1'b0);
    wait_done(d0, 40);

    // Single corrupted word: error recorded at the third beat.
    mem[8'h42] = 32'hDEAD_BEEF;
    d0 = done_seen;
    send_cmd(1'b0, 32'h0000_0100, 8'd4, 32'hA5A5_0000, 1, 1, 8'd1, 32'h0000_0108, 1'b0);
    wait_done(d0, 40);

    // Zero-length command: done without any bus cycle.
    d0 = done_seen;
    c0 = cyc_cycles;
    send_cmd(1'b1, 32'h0000_0200, 8'd0, 32'h1111_0000, 0, 1, 8'd0, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    check("len0_done_count", done_seen, d0 + 1);
    check("len0_no_cyc", cyc_cycles, c0);

    // Command held valid while busy must not be accepted (no extra beats appear).
    d0 = done_seen;
    send_cmd(1'b1, 32'hFFFF_FFF8, 8'd3, 32'hFFFF_FFFF, 1, 1, 8'd0, 32'h0, 1'b0);
    cmd_addr  = 32'h0000_0300;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("busy_ready_low", {31'b0, cmd_ready}, 32'd0);
      check("busy_high", {31'b0, busy_o}, 32'd1);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_done(d0, 40);

`ifdef WBM_TIMEOUT_EN
    ack_en = 1'b0;
    d0 = done_seen;
    c0 = cyc_cycles;
    send_cmd(1'b0, 32'h0000_0100, 8'd2, 32'h0, 0, 1, 8'd0, 32'h0, 1'b1);
    wait_done(d0, 60);
    check("timeout_cyc_cycles", cyc_cycles - c0, 32'd16);
    ack_en = 1'b1;
`endif

    // Reset during the second beat of an 8-beat write.
    ignore_beats = 1'b1;
    d0 = done_seen;
    a0 = ack_count;
    send_cmd(1'b1, 32'h0000_0300, 8'd8, 32'h0BAD_0000, 0, 0, 8'd0, 32'h0, 1'b0);
    guard = 0;
    while (!(wbm_cyc_o && ack_count == a0 + 1) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("reached_beat2", {31'b0, wbm_cyc_o}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("midrst_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("midrst_ready", {31'b0, cmd_ready}, 32'd1);
    check("midrst_err_cnt", {24'b0, err_cnt_o}, 32'd0);
    check("midrst_done", {31'b0, done_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("midrst_no_done", done_seen, d0);
    ignore_beats = 1'b0;

    check("beats_drained", beat_q.size(), 32'd0);
    check("results_drained", res_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
